// File: rtl/bus_ram_ctrl_pkg.sv
// Shared types, counter width and window decode for the sysbus RAM slave.
package ram_pkg;

    typedef enum logic {IDLE, WAIT} ram_state_t;

    localparam int unsigned CNT_W = 4;

    // True when addr is inside [base, base+depth) and outside the reserved I/O hole.
    function automatic logic win_hit(input int unsigned addr, input int unsigned base,
                                     input int unsigned depth, input int unsigned rsv_lo,
                                     input int unsigned rsv_hi);
        return (addr >= base) && (addr < base + depth) &&
               !((addr >= rsv_lo) && (addr <= rsv_hi));
    endfunction

endpackage

// File: rtl/bus_ram_ctrl_if.sv
// Sequencer <-> RAM slave control/status strobes (sysbus itself stays a plain inout).
interface bus_ram_ctrl_if;
    logic load_MAR;
    logic load_MDR;
    logic MDR_bus;
    logic CS;
    logic R_NW;
    logic hit;
    logic busy;
    logic ack;
    logic parity_err;

    modport master (output load_MAR, load_MDR, MDR_bus, CS, R_NW,
                    input  hit, busy, ack, parity_err);
    modport slave  (input  load_MAR, load_MDR, MDR_bus, CS, R_NW,
                    output hit, busy, ack, parity_err);
endinterface

// File: rtl/bus_ram_ctrl_array.sv
// Storage for the RAM slave: one synchronous write port, one registered read port, no reset.
module ram_array #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_ram_ctrl.sv
// Memory-mapped RAM slave with MAR/MDR, reserved I/O hole and programmable wait states.
// Optional per-word parity when RAM_PARITY_EN is defined.
module bus_ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned OP_W        = 3,
    parameter int unsigned BASE        = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RSV_LO      = 30,
    parameter int unsigned RSV_HI      = 31,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              n_reset,
    inout  wire [WORD_W-1:0]  sysbus,
    bus_ram_ctrl_if.slave     bus
);
    localparam int unsigned ADDR_W = WORD_W - OP_W;
    localparam int unsigned EXT_W  = ADDR_W + 1;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
    localparam int unsigned MEM_W  = WORD_W + 1;
`else
    localparam int unsigned MEM_W  = WORD_W;
`endif

    if (BASE + DEPTH > (32'd1 << ADDR_W)) begin : g_bad_window
        $error("bus_ram_ctrl: BASE+DEPTH exceeds address space");
    end
    if (RSV_LO > RSV_HI) begin : g_bad_rsv
        $error("bus_ram_ctrl: RSV_LO must not exceed RSV_HI");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("bus_ram_ctrl: WAIT_CYCLES must be 0..15");
    end

    ram_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [WORD_W-1:0] mdr_q, mdr_d;
    logic              rnw_q, rnw_d;
    logic              ack_q, ack_d;
    logic              pend_q, pend_d;

    logic              hit_c, sysbus_oe_c, commit_c, commit_rnw_c, we_c, re_c;
    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] mdr_vis_c;
    logic [MEM_W-1:0]  wdata_c, rd_word_c;

    assign hit_c = win_hit(32'(mar_q), BASE, DEPTH, RSV_LO, RSV_HI);
    assign idx_c = IDX_W'(EXT_W'(mar_q) - EXT_W'(BASE));

    // Read data lands in the array's output register; it is the live MDR until folded in.
    assign mdr_vis_c   = pend_q ? rd_word_c[WORD_W-1:0] : mdr_q;
    assign sysbus_oe_c = bus.MDR_bus && hit_c && (state_q == IDLE);
    assign sysbus      = sysbus_oe_c ? mdr_vis_c : {WORD_W{1'bz}};

`ifdef RAM_PARITY_EN
    assign wdata_c        = {^mdr_vis_c, mdr_vis_c};
    assign bus.parity_err = pend_q && (rd_word_c[WORD_W] != ^rd_word_c[WORD_W-1:0]);
`else
    assign wdata_c        = mdr_vis_c;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.hit  = hit_c;
    assign bus.busy = (state_q == WAIT);
    assign bus.ack  = ack_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            rnw_q   <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rnw_q   <= rnw_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    // Next state: loads win over access requests; commit happens on the last wait edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mar_d        = mar_q;
        mdr_d        = mdr_vis_c;
        rnw_d        = rnw_q;
        ack_d        = 1'b0;
        pend_d       = 1'b0;
        commit_c     = 1'b0;
        commit_rnw_c = 1'b0;
        we_c         = 1'b0;
        re_c         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_MAR) begin
                    mar_d = sysbus[ADDR_W-1:0];
                end else if (bus.load_MDR) begin
                    mdr_d = sysbus;
                end else if (bus.CS && hit_c) begin
                    rnw_d = bus.R_NW;
                    if (WAIT_CYCLES == 0) begin
                        commit_c     = 1'b1;
                        commit_rnw_c = bus.R_NW;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit_c     = 1'b1;
                    commit_rnw_c = rnw_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit_c) begin
            ack_d = 1'b1;
            if (commit_rnw_c) begin
                re_c   = 1'b1;
                pend_d = 1'b1;
            end else begin
                we_c = 1'b1;
            end
        end
    end

    ram_array #(.W(MEM_W), .DEPTH(DEPTH), .AW(IDX_W)) u_array (
        .clk     (clock),
        .we_i    (we_c),
        .waddr_i (idx_c),
        .wdata_i (wdata_c),
        .re_i    (re_c),
        .raddr_i (idx_c),
        .rdata_o (rd_word_c)
    );
endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Directed bench for bus_ram_ctrl: a zero-wait instance and a three-wait instance.
// Define RAM_PARITY_EN to include the parity-flip scenario.
module tb_bus_ram_ctrl;
    logic clock = 1'b0;
    logic n_reset0, n_reset3;
    int   n_checks = 0;
    int   n_errors = 0;

    wire  [7:0] bus0, bus3;
    logic [7:0] drv0, drv3;
    logic       en0, en3;
    assign bus0 = en0 ? drv0 : 8'bz;
    assign bus3 = en3 ? drv3 : 8'bz;

    bus_ram_ctrl_if if0 ();
    bus_ram_ctrl_if if3 ();

    bus_ram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .n_reset(n_reset0), .sysbus(bus0), .bus(if0));
    bus_ram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .n_reset(n_reset3), .sysbus(bus3), .bus(if3));

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic ld_mar0(input logic [7:0] a);
        en0 = 1'b1; drv0 = a; if0.load_MAR = 1'b1; cyc(); if0.load_MAR = 1'b0; en0 = 1'b0;
    endtask
    task automatic ld_mdr0(input logic [7:0] v);
        en0 = 1'b1; drv0 = v; if0.load_MDR = 1'b1; cyc(); if0.load_MDR = 1'b0; en0 = 1'b0;
    endtask
    task automatic access0(input logic rnw);
        if0.CS = 1'b1; if0.R_NW = rnw; cyc(); if0.CS = 1'b0;
    endtask
    task automatic bus_val0(output logic [7:0] v);
        if0.MDR_bus = 1'b1; #1; v = bus0; if0.MDR_bus = 1'b0; #1;
    endtask
    task automatic ld_mar3(input logic [7:0] a);
        en3 = 1'b1; drv3 = a; if3.load_MAR = 1'b1; cyc(); if3.load_MAR = 1'b0; en3 = 1'b0;
    endtask
    task automatic ld_mdr3(input logic [7:0] v);
        en3 = 1'b1; drv3 = v; if3.load_MDR = 1'b1; cyc(); if3.load_MDR = 1'b0; en3 = 1'b0;
    endtask
    task automatic access3(input logic rnw);
        if3.CS = 1'b1; if3.R_NW = rnw; cyc(); if3.CS = 1'b0; cyc(); cyc(); cyc();
    endtask
    task automatic bus_val3(output logic [7:0] v);
        if3.MDR_bus = 1'b1; #1; v = bus3; if3.MDR_bus = 1'b0; #1;
    endtask

    logic [7:0] miss_addr [3];
    logic [7:0] v;

    initial begin
        miss_addr[0] = 8'd30; miss_addr[1] = 8'd31; miss_addr[2] = 8'd5;
        n_reset0 = 1'b0; n_reset3 = 1'b0;
        en0 = 1'b0; en3 = 1'b0; drv0 = '0; drv3 = '0;
        {if0.load_MAR, if0.load_MDR, if0.MDR_bus, if0.CS, if0.R_NW} = '0;
        {if3.load_MAR, if3.load_MDR, if3.MDR_bus, if3.CS, if3.R_NW} = '0;
        #2;
        check("rst_busy", if0.busy, 1'b0);
        check("rst_ack", if0.ack, 1'b0);
        check("rst_perr", if0.parity_err, 1'b0);
        check("rst_hit", if0.hit, 1'b0);
        check("rst_busy3", if3.busy, 1'b0);
        cyc(); cyc();
        n_reset0 = 1'b1; n_reset3 = 1'b1;
        cyc();

        // Zero-wait write then read of address 16.
        ld_mar0(8'd16);
        check("hit16", if0.hit, 1'b1);
        ld_mdr0(8'hA5);
        access0(1'b0);
        check("wr_ack", if0.ack, 1'b1);
        check("wr_busy", if0.busy, 1'b0);
        cyc();
        check("wr_ack_drop", if0.ack, 1'b0);
        ld_mdr0(8'h00);
        access0(1'b1);
        check("rd_ack", if0.ack, 1'b1);
        check("rd_perr", if0.parity_err, 1'b0);
        bus_val0(v);
        check("rd_data16", 32'(v), 32'hA5);
        cyc();

        // Hole and out-of-window accesses must be ignored; 21 shares index with 5.
        ld_mar0(8'd21); ld_mdr0(8'h5A); access0(1'b0); cyc();
        ld_mdr0(8'hFF);
        for (int i = 0; i < 3; i++) begin
            ld_mar0(miss_addr[i]);
            check("miss_hit", if0.hit, 1'b0);
            if0.MDR_bus = 1'b1; if0.CS = 1'b1; if0.R_NW = 1'b0;
            #1;
            check("miss_oe", u_dut0.sysbus_oe_c, 1'b0);
            cyc();
            check("miss_ack", if0.ack, 1'b0);
            check("miss_busy", if0.busy, 1'b0);
            if0.CS = 1'b0; if0.MDR_bus = 1'b0;
        end
        ld_mar0(8'd21); access0(1'b1);
        check("miss_rd_ack", if0.ack, 1'b1);
        bus_val0(v);
        check("miss_mem21", 32'(v), 32'h5A);
        cyc();

        // Priority: load_MAR beats CS, then back-to-back reads of 17 and 18.
        ld_mar0(8'd17); ld_mdr0(8'h71); access0(1'b0);
        ld_mar0(8'd18); ld_mdr0(8'h82); access0(1'b0);
        cyc();
        en0 = 1'b1; drv0 = 8'd17; if0.load_MAR = 1'b1; if0.CS = 1'b1; if0.R_NW = 1'b1;
        cyc();
        if0.load_MAR = 1'b0; en0 = 1'b0;
        check("prio_ack", if0.ack, 1'b0);
        cyc();
        check("b2b_ack1", if0.ack, 1'b1);
        bus_val0(v);
        check("b2b_data17", 32'(v), 32'h71);
        cyc();
        check("b2b_ack2", if0.ack, 1'b1);
        en0 = 1'b1; drv0 = 8'd18; if0.load_MAR = 1'b1;
        cyc();
        if0.load_MAR = 1'b0; en0 = 1'b0;
        check("prio_ack2", if0.ack, 1'b0);
        cyc();
        check("b2b_ack3", if0.ack, 1'b1);
        bus_val0(v);
        check("b2b_data18", 32'(v), 32'h82);
        if0.CS = 1'b0;
        cyc();

`ifdef RAM_PARITY_EN
        // Corrupted stored parity must flag on read but still deliver the data.
        ld_mar0(8'd21); ld_mdr0(8'h0F); access0(1'b0); cyc();
        u_dut0.u_array.mem_q[5][8] = ~u_dut0.u_array.mem_q[5][8];
        ld_mdr0(8'h00);
        access0(1'b1);
        check("par_ack", if0.ack, 1'b1);
        check("par_err", if0.parity_err, 1'b1);
        bus_val0(v);
        check("par_data", 32'(v), 32'h0F);
        cyc();
        check("par_err_drop", if0.parity_err, 1'b0);
        ld_mar0(8'd16); access0(1'b1);
        check("par_clean", if0.parity_err, 1'b0);
        cyc();
`endif

        // Three wait states: busy after accept edge N through N+2, ack after N+3.
        ld_mar3(8'd16); ld_mdr3(8'hC3);
        if3.CS = 1'b1; if3.R_NW = 1'b0;
        cyc();
        if3.CS = 1'b0;
        check("w3_busyN", if3.busy, 1'b1);
        check("w3_ackN", if3.ack, 1'b0);
        en3 = 1'b1; drv3 = 8'h11; if3.load_MAR = 1'b1;
        cyc();
        check("w3_busyN1", if3.busy, 1'b1);
        check("w3_ackN1", if3.ack, 1'b0);
        if3.load_MAR = 1'b0; en3 = 1'b0; if3.MDR_bus = 1'b1;
        #1;
        check("w3_oe_busy", u_dut3.sysbus_oe_c, 1'b0);
        if3.MDR_bus = 1'b0;
        cyc();
        check("w3_busyN2", if3.busy, 1'b1);
        check("w3_ackN2", if3.ack, 1'b0);
        cyc();
        check("w3_busyN3", if3.busy, 1'b0);
        check("w3_ackN3", if3.ack, 1'b1);
        cyc();
        check("w3_ackN4", if3.ack, 1'b0);
        ld_mdr3(8'h00);
        access3(1'b0 ^ 1'b1);
        check("w3_rd_ack", if3.ack, 1'b1);
        bus_val3(v);
        check("w3_mar_held", 32'(v), 32'hC3);
        cyc();

        // Reset during WAIT aborts the pending write to 20.
        ld_mar3(8'd20); ld_mdr3(8'h77); access3(1'b0); cyc();
        ld_mdr3(8'h3C);
        if3.CS = 1'b1; if3.R_NW = 1'b0;
        cyc();
        if3.CS = 1'b0;
        cyc();
        n_reset3 = 1'b0;
        #1;
        check("rst_mid_busy", if3.busy, 1'b0);
        check("rst_mid_ack", if3.ack, 1'b0);
        cyc(); cyc(); cyc();
        n_reset3 = 1'b1;
        cyc();
        check("rst_mid_ack2", if3.ack, 1'b0);
        ld_mar3(8'd20);
        access3(1'b1);
        check("rst_rd_ack", if3.ack, 1'b1);
        bus_val3(v);
        check("rst_mem20", 32'(v), 32'h77);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
